// File: rtl/sonar_pkg.sv
// Shared constants and state encoding for the sonar
// receive-chain bring-up blocks.
package sonar_pkg;

  localparam int ADC_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } spi_resp_state_t;

endpackage

// File: rtl/spi_adc_responder_fifo.sv
// Single-clock sample queue with a combinational head view.
// Pointers carry one extra wrap bit to separate full from empty.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             wr_en, rd_en;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout  = mem_q[rd_q[AW-1:0]];

  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (wr_en) wr_d = wr_q + (AW+1)'(1);
    if (rd_en) rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset; the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/spi_adc_responder.sv
// SPI responder emulating one serial ADC channel: queued samples
// are shifted out MSB first under the controller's sclk/cs.
module spi_adc_responder
  import sonar_pkg::*;
#(
  parameter int DATA_WIDTH = ADC_DATA_WIDTH,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid_in,
  output logic                  sample_ready_out,
  input  logic                  chip_clk_in,
  input  logic                  chip_sel_in,
  output logic                  chip_data_out,
  output logic                  busy_out,
  output logic                  underrun_out,
  output logic                  abort_out
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  spi_resp_state_t state_q, state_d;

  logic [2:0]            cs_sync_q, cs_sync_d;
  logic [2:0]            ck_sync_q, ck_sync_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  data_q, data_d;
  logic                  underrun_q, underrun_d;
  logic                  abort_q, abort_d;

  logic                  cs_fall, cs_rise;
  logic                  ck_rise, ck_fall;
  logic                  fifo_pop, fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_in),
    .rst   (rst_in),
    .push  (sample_valid_in),
    .pop   (fifo_pop),
    .din   (sample_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign sample_ready_out = ~fifo_full;
  assign chip_data_out    = data_q;
  assign busy_out         = (state_q != IDLE);
  assign underrun_out     = underrun_q;
  assign abort_out        = abort_q;

  // Bits [1:0] synchronize; bit 2 is the previous value for edges.
  assign cs_sync_d = {cs_sync_q[1:0], chip_sel_in};
  assign ck_sync_d = {ck_sync_q[1:0], chip_clk_in};

  assign cs_fall = ~cs_sync_q[1] &  cs_sync_q[2];
  assign cs_rise =  cs_sync_q[1] & ~cs_sync_q[2];
  assign ck_rise =  ck_sync_q[1] & ~ck_sync_q[2];
  assign ck_fall = ~ck_sync_q[1] &  ck_sync_q[2];

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    data_d     = 1'b0;
    underrun_d = 1'b0;
    abort_d    = 1'b0;
    fifo_pop   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          fifo_pop   = ~fifo_empty;
          underrun_d = fifo_empty;
          shift_d    = fifo_empty ? '0 : fifo_dout;
          data_d     = shift_d[DATA_WIDTH-1];
          bit_cnt_d  = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        data_d = data_q;
        if (cs_rise) begin
          abort_d = 1'b1;
          data_d  = 1'b0;
          state_d = IDLE;
        end else if (ck_rise) begin
          bit_cnt_d = bit_cnt_q + CW'(1);
          if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
            data_d  = 1'b0;
            state_d = DONE;
          end
        end else if (ck_fall) begin
          shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
          data_d  = shift_d[DATA_WIDTH-1];
        end
      end
      DONE: begin
        if (cs_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      cs_sync_q  <= 3'b111;
      ck_sync_q  <= 3'b000;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      data_q     <= 1'b0;
      underrun_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cs_sync_q  <= cs_sync_d;
      ck_sync_q  <= ck_sync_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      underrun_q <= underrun_d;
      abort_q    <= abort_d;
    end
  end

endmodule
